// File: rtl/ascon_pkg.sv
// Shared ASCON definitions: packer FSM states and rate/padding constants.
package ascon_pkg;

  localparam int         ASCON_RATE_BYTES = 8;
  localparam logic [7:0] ASCON_PAD_BYTE   = 8'h80;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    PAD  = 2'd2
  } t_packer_state;

endpackage

// File: rtl/ascon_pad_lane.sv
// Big-endian lane placement for one byte at index idx plus the trailing pad byte;
// also usable by the associated-data path.
module ascon_pad_lane
  import ascon_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = ASCON_PAD_BYTE
) (
  input  logic [2:0]  idx,
  input  logic [7:0]  data,
  output logic [63:0] byte_word,
  output logic [63:0] byte_mask,
  output logic [63:0] pad_word,
  output logic [63:0] tail_mask
);

  logic [5:0] shift_s;

  // Lane 7-idx holds the byte; pad lands one lane lower and vanishes when idx==7.
  always_comb begin
    shift_s   = {3'd7 - idx, 3'b000};
    byte_word = {56'h0, data} << shift_s;
    byte_mask = {56'h0, 8'hFF} << shift_s;
    tail_mask = ({63'h0, 1'b1} << shift_s) - 64'd1;
    pad_word  = ({56'h0, PAD_BYTE} << shift_s) >> 6'd8;
  end

endmodule

// File: rtl/ascon_block_packer.sv
// Packs a plaintext byte stream into padded 64-bit ASCON rate blocks.
// Optional block-handshake counter port o_stat_blocks under ASCON_PACKER_STATS_EN.
module ascon_block_packer
  import ascon_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE   = ASCON_PAD_BYTE,
  parameter int         MAX_BLOCKS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_sys_enable,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  input  logic        i_byte_last,
  output logic        o_byte_ready,
  input  logic        i_empty_msg,
  output logic [63:0] o_block,
  output logic        o_block_valid,
  input  logic        i_block_ready,
  output logic        o_block_last,
  output logic [3:0]  o_block_nbytes,
  output logic        o_overflow
`ifdef ASCON_PACKER_STATS_EN
  ,
  output logic [15:0] o_stat_blocks
`endif
);

  localparam logic [2:0]  LAST_IDX  = 3'(ASCON_RATE_BYTES - 1);
  localparam logic [3:0]  CNT_TOP   = 4'(MAX_BLOCKS - 1);
  localparam logic [63:0] PAD_BLOCK = {PAD_BYTE, 56'h0};

  t_packer_state state_r, state_n;
  logic [2:0]    idx_r, idx_n;
  logic [3:0]    blk_cnt_r, blk_cnt_n;
  logic [63:0]   block_r, block_n;
  logic          last_r, last_n;
  logic [3:0]    nbytes_r, nbytes_n;
  logic          valid_r, valid_n;
  logic          pad_pending_r, pad_pending_n;
  logic          overflow_r, overflow_n;

  logic          byte_fire_s, blk_fire_s, empty_req_s;
  logic [63:0]   byte_word_s, byte_mask_s, pad_word_s, tail_mask_s;

  ascon_pad_lane #(.PAD_BYTE(PAD_BYTE)) u_pad_lane (
    .idx       (idx_r),
    .data      (i_byte),
    .byte_word (byte_word_s),
    .byte_mask (byte_mask_s),
    .pad_word  (pad_word_s),
    .tail_mask (tail_mask_s)
  );

  assign empty_req_s  = i_empty_msg && (idx_r == 3'd0);
  assign o_byte_ready = (state_r == FILL) && i_sys_enable && !empty_req_s && !reset;
  assign byte_fire_s  = i_byte_valid && o_byte_ready;
  assign blk_fire_s   = valid_r && i_block_ready && i_sys_enable;

  // Next-state and datapath decode; everything holds while disabled.
  always_comb begin
    state_n       = state_r;
    idx_n         = idx_r;
    blk_cnt_n     = blk_cnt_r;
    block_n       = block_r;
    last_n        = last_r;
    nbytes_n      = nbytes_r;
    valid_n       = valid_r;
    pad_pending_n = pad_pending_r;
    overflow_n    = overflow_r;
    if (i_sys_enable) begin
      case (state_r)
        FILL: begin
          if (empty_req_s) begin
            block_n  = PAD_BLOCK;
            last_n   = 1'b1;
            nbytes_n = 4'd0;
            valid_n  = 1'b1;
            state_n  = HOLD;
          end else if (byte_fire_s && i_byte_last) begin
            block_n = (block_r & ~(byte_mask_s | tail_mask_s)) | byte_word_s | pad_word_s;
            idx_n   = 3'd0;
            valid_n = 1'b1;
            state_n = HOLD;
            if (idx_r == LAST_IDX) begin
              last_n        = 1'b0;
              nbytes_n      = 4'd8;
              pad_pending_n = 1'b1;
            end else begin
              last_n   = 1'b1;
              nbytes_n = {1'b0, idx_r} + 4'd1;
            end
          end else if (byte_fire_s) begin
            block_n = (block_r & ~byte_mask_s) | byte_word_s;
            if (idx_r == LAST_IDX) begin
              idx_n    = 3'd0;
              last_n   = 1'b0;
              nbytes_n = 4'd8;
              valid_n  = 1'b1;
              state_n  = HOLD;
            end else begin
              idx_n = idx_r + 3'd1;
            end
          end else begin
            state_n = FILL;
          end
        end
        HOLD: begin
          if (blk_fire_s) begin
            valid_n = 1'b0;
            if (blk_cnt_r == CNT_TOP) begin
              overflow_n = overflow_r | !last_r;
            end else begin
              blk_cnt_n = blk_cnt_r + 4'd1;
            end
            if (pad_pending_r) begin
              state_n = PAD;
            end else begin
              state_n  = FILL;
              block_n  = 64'h0;
              last_n   = 1'b0;
              nbytes_n = 4'd0;
              if (last_r) begin
                blk_cnt_n = 4'd0;
              end else begin
                blk_cnt_n = blk_cnt_n;
              end
            end
          end else begin
            state_n = HOLD;
          end
        end
        PAD: begin
          block_n       = PAD_BLOCK;
          last_n        = 1'b1;
          nbytes_n      = 4'd0;
          pad_pending_n = 1'b0;
          valid_n       = 1'b1;
          state_n       = HOLD;
        end
        default: begin
          state_n = FILL;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= FILL;
      idx_r         <= 3'd0;
      blk_cnt_r     <= 4'd0;
      block_r       <= 64'h0;
      last_r        <= 1'b0;
      nbytes_r      <= 4'd0;
      valid_r       <= 1'b0;
      pad_pending_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      state_r       <= state_n;
      idx_r         <= idx_n;
      blk_cnt_r     <= blk_cnt_n;
      block_r       <= block_n;
      last_r        <= last_n;
      nbytes_r      <= nbytes_n;
      valid_r       <= valid_n;
      pad_pending_r <= pad_pending_n;
      overflow_r    <= overflow_n;
    end
  end

  assign o_block        = block_r;
  assign o_block_valid  = valid_r;
  assign o_block_last   = last_r;
  assign o_block_nbytes = nbytes_r;
  assign o_overflow     = overflow_r;

`ifdef ASCON_PACKER_STATS_EN
  logic [15:0] stat_r;

  // Free-running block handshake counter, wraps at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_r <= 16'd0;
    end else if (blk_fire_s) begin
      stat_r <= stat_r + 16'd1;
    end else begin
      stat_r <= stat_r;
    end
  end

  assign o_stat_blocks = stat_r;
`endif

endmodule
